// File: rtl/regblock_seq_ctrl.sv
// regblock_seq_ctrl: serial IDLE->READ->EXEC->WB sequencer that decodes one instruction word and drives RegBlock.
// Build option: define RETIRE_CNT_EN to add the 16-bit wrapping retire_cnt output.

module regblock_seq_ctrl #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32,
  parameter int IMM_IN = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [DWIDTH-1:0] alu_result,
  output logic [RWIDTH-1:0] rs,
  output logic [RWIDTH-1:0] rt,
  output logic [RWIDTH-1:0] rd,
  output logic              we,
  output logic              muxsel1,
  output logic [IMM_IN-1:0] imm_in,
  output logic [3:0]        ALUopsel,
  output logic [DWIDTH-1:0] wd,
  output logic              done
`ifdef RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam logic [3:0] OP_SPECIAL = 4'b1111;

  state_e            state_q, state_d;
  logic [RWIDTH-1:0] rs_q, rs_d;
  logic [RWIDTH-1:0] rt_q, rt_d;
  logic [RWIDTH-1:0] rd_q, rd_d;
  logic [IMM_IN-1:0] imm_q, imm_d;
  logic              muxsel1_q, muxsel1_d;
  logic [3:0]        aluop_q, aluop_d;
  logic [DWIDTH-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              ldi_q, ldi_d;
  logic              nop_q, nop_d;

  // Next-state, decode on acceptance, write-back capture in EXEC.
  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    muxsel1_d = muxsel1_q;
    aluop_d   = aluop_q;
    wd_d      = wd_q;
    ldi_d     = ldi_q;
    nop_d     = nop_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          aluop_d   = instr[31:28];
          muxsel1_d = instr[27];
          rd_d      = instr[26:21];
          rs_d      = instr[20:15];
          rt_d      = instr[14:9];
          imm_d     = instr[IMM_IN-1:0];
          ldi_d     = (instr[31:28] == OP_SPECIAL) && instr[27];
          nop_d     = (instr[31:28] == OP_SPECIAL) && !instr[27];
          state_d   = READ;
        end else begin
          state_d   = IDLE;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        if (ldi_q) begin
          wd_d = {{(DWIDTH-IMM_IN){1'b0}}, imm_q};
        end else begin
          wd_d = alu_result;
        end
        // we/done are registered, so they are raised on the edge entering WB.
        we_d    = !nop_q;
        done_d  = 1'b1;
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rs_q      <= {RWIDTH{1'b0}};
      rt_q      <= {RWIDTH{1'b0}};
      rd_q      <= {RWIDTH{1'b0}};
      imm_q     <= {IMM_IN{1'b0}};
      muxsel1_q <= 1'b0;
      aluop_q   <= 4'b1111;
      wd_q      <= {DWIDTH{1'b0}};
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      ldi_q     <= 1'b0;
      nop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      muxsel1_q <= muxsel1_d;
      aluop_q   <= aluop_d;
      wd_q      <= wd_d;
      we_q      <= we_d;
      done_q    <= done_d;
      ldi_q     <= ldi_d;
      nop_q     <= nop_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign rs          = rs_q;
  assign rt          = rt_q;
  assign rd          = rd_q;
  assign imm_in      = imm_q;
  assign muxsel1     = muxsel1_q;
  assign ALUopsel    = aluop_q;
  assign wd          = wd_q;
  assign we          = we_q;
  assign done        = done_q;

`ifdef RETIRE_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;

  // Counter steps with the same edge that raises done, so it reads the new total during WB.
  always_comb begin
    if (done_d) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // Retire counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= 16'd0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_regblock_seq_ctrl.sv
// Self-checking bench for regblock_seq_ctrl: directed and random instructions against an
// architectural register-file model that also plays the role of RegBlock's ALU.

module tb_regblock_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic [5:0]  rs, rt, rd;
  logic        we, muxsel1, done;
  logic [14:0] imm_in;
  logic [3:0]  ALUopsel;
  logic [31:0] wd;
`ifdef RETIRE_CNT_EN
  logic [15:0] retire_cnt;
  int          exp_retire;
`endif

  int          n_checks;
  int          n_pass;
  logic [31:0] ref_rf [64];

  regblock_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_result  (alu_result),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .we          (we),
    .muxsel1     (muxsel1),
    .imm_in      (imm_in),
    .ALUopsel    (ALUopsel),
    .wd          (wd),
    .done        (done)
`ifdef RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a & b;
      4'd2:    return a | b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // RegBlock stand-in: reads the model register file at the addresses the DUT drives.
  assign alu_result = alu_f(ALUopsel, ref_rf[rs], muxsel1 ? {17'd0, imm_in} : ref_rf[rt]);

  // Architectural result of one instruction given the current model register file.
  function automatic logic [31:0] exp_value(input logic [31:0] w);
    if (w[31:28] == 4'hF) return {17'd0, w[14:0]};
    if (w[27])            return alu_f(w[31:28], ref_rf[w[20:15]], {17'd0, w[14:0]});
    return alu_f(w[31:28], ref_rf[w[20:15]], ref_rf[w[14:9]]);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_instr(input logic [31:0] w);
    logic        is_nop;
    logic [31:0] ev;
    is_nop = (w[31:28] == 4'hF) && !w[27];
    ev     = exp_value(w);
    @(negedge clk);
    check_eq("ready_idle", 32'(instr_ready), 32'd1);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check_eq("read_ready", 32'(instr_ready), 32'd0);
    check_eq("read_rd", 32'(rd), 32'(w[26:21]));
    check_eq("read_rs", 32'(rs), 32'(w[20:15]));
    if (!w[27]) check_eq("read_rt", 32'(rt), 32'(w[14:9]));
    else        check_eq("read_imm", 32'(imm_in), 32'(w[14:0]));
    check_eq("read_mux", 32'(muxsel1), 32'(w[27]));
    check_eq("read_op", 32'(ALUopsel), 32'(w[31:28]));
    check_eq("read_we", 32'({we, done}), 32'd0);
    @(posedge clk); #1;
    check_eq("exec_we_done", 32'({we, done}), 32'd0);
    @(posedge clk); #1;
    check_eq("wb_done", 32'(done), 32'd1);
    check_eq("wb_we", 32'(we), 32'(!is_nop));
    if (!is_nop) begin
      check_eq("wb_rd", 32'(rd), 32'(w[26:21]));
      check_eq("wb_wd", wd, ev);
      ref_rf[w[26:21]] = ev;
    end
`ifdef RETIRE_CNT_EN
    exp_retire = (exp_retire + 1) % 65536;
    check_eq("retire_cnt", 32'(retire_cnt), 32'(exp_retire));
`endif
    @(posedge clk); #1;
    check_eq("idle_we_done", 32'({we, done}), 32'd0);
    check_eq("idle_ready", 32'(instr_ready), 32'd1);
  endtask

  task automatic back_to_back();
    logic [31:0] words [3];
    int          acc_cyc [3];
    int          idx, ndone, last_acc;
    logic        exp_ready;
    words[0] = {4'hF, 1'b1, 6'd1, 6'd0, 15'd5};
    words[1] = {4'hF, 1'b1, 6'd2, 6'd0, 15'd9};
    words[2] = {4'h0, 1'b0, 6'd3, 6'd1, 6'd2, 9'd0};
    idx = 0; ndone = 0; last_acc = -10;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_ready = (c > last_acc + 3);
      check_eq("b2b_ready", 32'(instr_ready), 32'(exp_ready));
      if (done) begin
        if (ndone < 3) begin
          check_eq("b2b_latency", 32'(c - acc_cyc[ndone]), 32'd3);
          check_eq("b2b_rd", 32'(rd), 32'(words[ndone][26:21]));
          check_eq("b2b_wd", wd, exp_value(words[ndone]));
          ref_rf[words[ndone][26:21]] = exp_value(words[ndone]);
`ifdef RETIRE_CNT_EN
          exp_retire = (exp_retire + 1) % 65536;
`endif
        end
        ndone++;
      end
      instr_valid = (idx < 3);
      instr       = (idx < 3) ? words[idx] : 32'd0;
      if (instr_valid && exp_ready) begin
        acc_cyc[idx] = c;
        last_acc     = c;
        idx++;
      end
    end
    instr_valid = 1'b0;
    check_eq("b2b_done_count", 32'(ndone), 32'd3);
    check_eq("b2b_accepted", 32'(idx), 32'd3);
    check_eq("b2b_r3", ref_rf[3], 32'd14);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rs_rt_rd"}, 32'({rs, rt, rd}), 32'd0);
    check_eq({tag, "_wd"}, wd, 32'd0);
    check_eq({tag, "_imm_mux"}, 32'({imm_in, muxsel1}), 32'd0);
    check_eq({tag, "_aluop"}, 32'(ALUopsel), 32'hF);
    check_eq({tag, "_we_done"}, 32'({we, done}), 32'd0);
    check_eq({tag, "_ready"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
`ifdef RETIRE_CNT_EN
    exp_retire  = 0;
`endif
    for (int i = 0; i < 64; i++) ref_rf[i] = 32'h0101_0101 * 32'(i);
    #12;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_instr({4'hF, 1'b1, 6'd7, 6'd0, 15'h2AAA});
    run_instr({4'hF, 1'b1, 6'd56, 6'd0, 15'h1111});
    run_instr({4'h0, 1'b0, 6'd63, 6'd7, 6'd56, 9'd0});
    check_eq("add_r63", ref_rf[63], 32'h0000_3BBB);
    run_instr({4'h3, 1'b1, 6'd51, 6'd7, 15'h0AA9});
    check_eq("subi_r51", ref_rf[51], 32'h0000_2001);
    for (int i = 0; i < 5; i++) run_instr({4'hF, 1'b0, 6'd10, 6'd7, 15'h0123});

    back_to_back();

    for (int i = 0; i < 40; i++) run_instr($urandom());

    // Reset arriving mid-EXEC must drop the ADD to r63.
    @(negedge clk);
    instr       = {4'h0, 1'b0, 6'd63, 6'd7, 6'd7, 9'd0};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    check_eq("midrst_we_low", 32'(we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef RETIRE_CNT_EN
    exp_retire = 0;
    check_eq("retire_after_rst", 32'(retire_cnt), 32'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_we_done", 32'({we, done}), 32'd0);
      check_eq("post_rst_ready", 32'(instr_ready), 32'd1);
    end
    run_instr({4'h0, 1'b0, 6'd20, 6'd63, 6'd0, 9'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
